// File: rtl/ex_pkg.sv
// Shared constants, types and helpers for the OpenMIPS execute stage.
// Opcode and result-class encodings match the decoder's encodings.
package ex_pkg;

  localparam int ALUOP_W  = 8;
  localparam int ALUSEL_W = 3;

  localparam logic        RST_ENABLE    = 1'b1;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG_ADDR  = 5'b00000;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [ALUOP_W-1:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [ALUOP_W-1:0] EXE_MOVZ_OP  = 8'b0000_1010;
  localparam logic [ALUOP_W-1:0] EXE_MOVN_OP  = 8'b0000_1011;
  localparam logic [ALUOP_W-1:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [ALUOP_W-1:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [ALUOP_W-1:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [ALUOP_W-1:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;

  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [ALUSEL_W-1:0] EXE_RES_MOVE  = 3'b011;

  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_BUSY = 2'd1,
    MULT_DONE = 2'd2
  } mult_state_e;

  // Magnitude of a two's-complement word; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_if.sv
// Execute-stage bundle: decoded operation in, GPR and HI/LO write-back out.
// The slave side is the execute stage; the master side is the surrounding pipeline.
interface ex_if;
  import ex_pkg::*;

  logic [ALUOP_W-1:0]  aluop_i;
  logic [ALUSEL_W-1:0] alusel_i;
  logic [31:0]         reg1_i;
  logic [31:0]         reg2_i;
  logic [4:0]          wd_i;
  logic                wreg_i;
  logic [31:0]         hi_i;
  logic [31:0]         lo_i;
  logic                mem_whilo_i;
  logic [31:0]         mem_hi_i;
  logic [31:0]         mem_lo_i;
  logic                wb_whilo_i;
  logic [31:0]         wb_hi_i;
  logic [31:0]         wb_lo_i;

  logic [4:0]          wd_o;
  logic                wreg_o;
  logic [31:0]         wdata_o;
  logic                whilo_o;
  logic [31:0]         hi_o;
  logic [31:0]         lo_o;
  logic                stallreq_o;

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    input  hi_i, lo_i, mem_whilo_i, mem_hi_i, mem_lo_i,
    input  wb_whilo_i, wb_hi_i, wb_lo_i,
    output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    output hi_i, lo_i, mem_whilo_i, mem_hi_i, mem_lo_i,
    output wb_whilo_i, wb_hi_i, wb_lo_i,
    input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );

endinterface

// File: rtl/ex_mult_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle on operand
// magnitudes, with the sign applied to the 64-bit accumulator on output.
module mult_iter
  import ex_pkg::*;
#(
  parameter int MULT_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  localparam int CNT_W = (MULT_ITER > 1) ? $clog2(MULT_ITER) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MULT_ITER - 1);

  mult_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]     acc_q;
  logic [31:0]     mcand_q, mplier_q;
  logic            neg_q;
  logic [31:0]     mag_a, mag_b;

  assign mag_a = signed_op ? abs32(opa) : opa;
  assign mag_b = signed_op ? abs32(opb) : opb;

  always_ff @(posedge clk) begin
    if (rst) state_q <= MULT_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      MULT_IDLE: begin
        if (start) begin
          busy    = 1'b1;
          state_d = (mag_a == 32'd0 || mag_b == 32'd0) ? MULT_DONE : MULT_BUSY;
        end
      end
      MULT_BUSY: begin
        busy = 1'b1;
        if (cnt_q == LAST_ITER) state_d = MULT_DONE;
      end
      MULT_DONE: begin
        done    = 1'b1;
        state_d = MULT_IDLE;
      end
      default: state_d = MULT_IDLE;
    endcase
  end

  // Operands are captured only on issue; upstream holds them during the stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= 64'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      neg_q    <= 1'b0;
    end else begin
      case (state_q)
        MULT_IDLE: begin
          if (start) begin
            mcand_q  <= mag_a;
            mplier_q <= mag_b;
            neg_q    <= signed_op & (opa[31] ^ opb[31]);
            cnt_q    <= '0;
            acc_q    <= 64'd0;
          end
        end
        MULT_BUSY: begin
          if (mplier_q[cnt_q]) acc_q <= acc_q + ({32'd0, mcand_q} << cnt_q);
          cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign result = neg_q ? (64'd0 - acc_q) : acc_q;

endmodule

// File: rtl/ex.sv
// OpenMIPS execute stage: combinational logic/shift/move ALU, HI/LO
// forwarding and write-back muxing around an iterative multiplier.
module ex
  import ex_pkg::*;
#(
  parameter int MULT_ITER = 32
) (
  input logic clk,
  input logic rst,
  ex_if.slave bus
);

  logic [31:0] hi_cur, lo_cur;
  logic [31:0] logic_res, shift_res, move_res, wdata;
  logic [4:0]  sa;
  logic        is_mult, is_signed_mult;
  logic        mult_busy, mult_done;
  logic [63:0] mult_res;

  assign sa             = bus.reg1_i[4:0];
  assign is_signed_mult = (bus.aluop_i == EXE_MULT_OP);
  assign is_mult        = is_signed_mult || (bus.aluop_i == EXE_MULTU_OP);

  // Youngest in-flight HI/LO write wins over the architectural copy.
  always_comb begin
    hi_cur = bus.hi_i;
    lo_cur = bus.lo_i;
    if (bus.mem_whilo_i) begin
      hi_cur = bus.mem_hi_i;
      lo_cur = bus.mem_lo_i;
    end else if (bus.wb_whilo_i) begin
      hi_cur = bus.wb_hi_i;
      lo_cur = bus.wb_lo_i;
    end
  end

  always_comb begin
    logic_res = ZERO_WORD;
    shift_res = ZERO_WORD;
    move_res  = ZERO_WORD;
    case (bus.aluop_i)
      EXE_OR_OP:   logic_res = bus.reg1_i | bus.reg2_i;
      EXE_AND_OP:  logic_res = bus.reg1_i & bus.reg2_i;
      EXE_XOR_OP:  logic_res = bus.reg1_i ^ bus.reg2_i;
      EXE_NOR_OP:  logic_res = ~(bus.reg1_i | bus.reg2_i);
      EXE_SLL_OP:  shift_res = bus.reg2_i << sa;
      EXE_SRL_OP:  shift_res = bus.reg2_i >> sa;
      EXE_SRA_OP:  shift_res = $signed(bus.reg2_i) >>> sa;
      EXE_MFHI_OP: move_res  = hi_cur;
      EXE_MFLO_OP: move_res  = lo_cur;
      EXE_MOVN_OP,
      EXE_MOVZ_OP: move_res  = bus.reg1_i;
      default: ;
    endcase
  end

  always_comb begin
    case (bus.alusel_i)
      EXE_RES_LOGIC: wdata = logic_res;
      EXE_RES_SHIFT: wdata = shift_res;
      EXE_RES_MOVE:  wdata = move_res;
      default:       wdata = ZERO_WORD;
    endcase
  end

  mult_iter #(
    .MULT_ITER(MULT_ITER)
  ) u_mult (
    .clk       (clk),
    .rst       (rst),
    .start     (is_mult),
    .signed_op (is_signed_mult),
    .opa       (bus.reg1_i),
    .opb       (bus.reg2_i),
    .busy      (mult_busy),
    .done      (mult_done),
    .result    (mult_res)
  );

  // Everything is forced quiet while reset is held, including the stall request.
  always_comb begin
    bus.wd_o       = NOP_REG_ADDR;
    bus.wreg_o     = WRITE_DISABLE;
    bus.wdata_o    = ZERO_WORD;
    bus.whilo_o    = WRITE_DISABLE;
    bus.hi_o       = ZERO_WORD;
    bus.lo_o       = ZERO_WORD;
    bus.stallreq_o = 1'b0;
    if (rst != RST_ENABLE) begin
      bus.wd_o       = bus.wd_i;
      bus.wreg_o     = is_mult ? WRITE_DISABLE : bus.wreg_i;
      bus.wdata_o    = wdata;
      bus.stallreq_o = mult_busy;
      if (mult_done) begin
        bus.whilo_o           = WRITE_ENABLE;
        {bus.hi_o, bus.lo_o}  = mult_res;
      end else if (bus.aluop_i == EXE_MTHI_OP) begin
        bus.whilo_o = WRITE_ENABLE;
        bus.hi_o    = bus.reg1_i;
        bus.lo_o    = lo_cur;
      end else if (bus.aluop_i == EXE_MTLO_OP) begin
        bus.whilo_o = WRITE_ENABLE;
        bus.hi_o    = hi_cur;
        bus.lo_o    = bus.reg1_i;
      end
    end
  end

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for the execute stage: directed cases plus randomized
// ALU ops and multiplies against an arithmetic reference model.
module tb_ex;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cmp_count = 0;
  int   err_count = 0;

  ex_if bus();

  ex #(.MULT_ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] op;
    logic [2:0] sel;
  } opsel_t;

  opsel_t ops[13];

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    cmp_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [2:0] sel,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [4:0] wd, input logic wreg);
    @(negedge clk);
    bus.aluop_i  = op;
    bus.alusel_i = sel;
    bus.reg1_i   = r1;
    bus.reg2_i   = r2;
    bus.wd_i     = wd;
    bus.wreg_i   = wreg;
    #1;
  endtask

  task automatic setHilo(input logic [31:0] hi, input logic [31:0] lo,
                         input logic mw, input logic [31:0] mh, input logic [31:0] ml,
                         input logic ww, input logic [31:0] wh, input logic [31:0] wl);
    bus.hi_i        = hi;
    bus.lo_i        = lo;
    bus.mem_whilo_i = mw;
    bus.mem_hi_i    = mh;
    bus.mem_lo_i    = ml;
    bus.wb_whilo_i  = ww;
    bus.wb_hi_i     = wh;
    bus.wb_lo_i     = wl;
  endtask

  function automatic logic [63:0] refHilo();
    if (bus.mem_whilo_i) return {bus.mem_hi_i, bus.mem_lo_i};
    if (bus.wb_whilo_i)  return {bus.wb_hi_i, bus.wb_lo_i};
    return {bus.hi_i, bus.lo_i};
  endfunction

  function automatic logic [31:0] refWdata(input logic [7:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] hl);
    int unsigned s;
    s = a[4:0];
    case (op)
      EXE_OR_OP:   return a | b;
      EXE_AND_OP:  return a & b;
      EXE_XOR_OP:  return a ^ b;
      EXE_NOR_OP:  return ~(a | b);
      EXE_SLL_OP:  return b << s;
      EXE_SRL_OP:  return b >> s;
      EXE_SRA_OP:  return b[31] ? ~((~b) >> s) : (b >> s);
      EXE_MFHI_OP: return hl[63:32];
      EXE_MFLO_OP: return hl[31:0];
      EXE_MOVN_OP, EXE_MOVZ_OP: return a;
      default:     return 32'd0;
    endcase
  endfunction

  // Full output check of a single-cycle op using the current bus inputs.
  task automatic checkComb(input string tag);
    logic [63:0] hl;
    logic        exp_whilo;
    hl        = refHilo();
    exp_whilo = (bus.aluop_i == EXE_MTHI_OP) || (bus.aluop_i == EXE_MTLO_OP);
    checkOutput({tag, ".wdata"}, {32'd0, bus.wdata_o},
                {32'd0, refWdata(bus.aluop_i, bus.reg1_i, bus.reg2_i, hl)});
    checkOutput({tag, ".wd"}, {59'd0, bus.wd_o}, {59'd0, bus.wd_i});
    checkOutput({tag, ".wreg"}, {63'd0, bus.wreg_o}, {63'd0, bus.wreg_i});
    checkOutput({tag, ".stall"}, {63'd0, bus.stallreq_o}, 64'd0);
    checkOutput({tag, ".whilo"}, {63'd0, bus.whilo_o}, {63'd0, exp_whilo});
    if (bus.aluop_i == EXE_MTHI_OP)
      checkOutput({tag, ".hilo"}, {bus.hi_o, bus.lo_o}, {bus.reg1_i, hl[31:0]});
    else if (bus.aluop_i == EXE_MTLO_OP)
      checkOutput({tag, ".hilo"}, {bus.hi_o, bus.lo_o}, {hl[63:32], bus.reg1_i});
  endtask

  task automatic runMult(input logic is_signed, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
    logic [63:0] ea, eb, exp_p;
    int          stalls, early_whilo, exp_stalls;
    ea = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    eb = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    exp_p       = ea * eb;
    exp_stalls  = (a == 32'd0 || b == 32'd0) ? 1 : 33;
    stalls      = 0;
    early_whilo = 0;
    applyStimulus(is_signed ? EXE_MULT_OP : EXE_MULTU_OP, EXE_RES_NOP, a, b, 5'd9, 1'b1);
    while (bus.stallreq_o === 1'b1 && stalls < 200) begin
      stalls++;
      if (bus.whilo_o !== 1'b0) early_whilo++;
      @(negedge clk);
      #1;
    end
    checkOutput({tag, ".stalls"}, 64'(stalls), 64'(exp_stalls));
    checkOutput({tag, ".early_whilo"}, 64'(early_whilo), 64'd0);
    checkOutput({tag, ".whilo"}, {63'd0, bus.whilo_o}, 64'd1);
    checkOutput({tag, ".product"}, {bus.hi_o, bus.lo_o}, exp_p);
    checkOutput({tag, ".wreg"}, {63'd0, bus.wreg_o}, 64'd0);
    bus.aluop_i = EXE_NOP_OP;
    @(negedge clk);
    #1;
    checkOutput({tag, ".retire_once"}, {63'd0, bus.whilo_o}, 64'd0);
    checkOutput({tag, ".idle_stall"}, {63'd0, bus.stallreq_o}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ops[0]  = '{EXE_OR_OP,   EXE_RES_LOGIC};
    ops[1]  = '{EXE_AND_OP,  EXE_RES_LOGIC};
    ops[2]  = '{EXE_XOR_OP,  EXE_RES_LOGIC};
    ops[3]  = '{EXE_NOR_OP,  EXE_RES_LOGIC};
    ops[4]  = '{EXE_SLL_OP,  EXE_RES_SHIFT};
    ops[5]  = '{EXE_SRL_OP,  EXE_RES_SHIFT};
    ops[6]  = '{EXE_SRA_OP,  EXE_RES_SHIFT};
    ops[7]  = '{EXE_MFHI_OP, EXE_RES_MOVE};
    ops[8]  = '{EXE_MFLO_OP, EXE_RES_MOVE};
    ops[9]  = '{EXE_MOVN_OP, EXE_RES_MOVE};
    ops[10] = '{EXE_MOVZ_OP, EXE_RES_MOVE};
    ops[11] = '{EXE_MTHI_OP, EXE_RES_NOP};
    ops[12] = '{EXE_MTLO_OP, EXE_RES_NOP};

    setHilo(32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    applyStimulus(EXE_MULT_OP, EXE_RES_LOGIC, 32'h1234_5678, 32'h9, 5'd7, 1'b1);
    checkOutput("reset.wdata", {32'd0, bus.wdata_o}, 64'd0);
    checkOutput("reset.wd", {59'd0, bus.wd_o}, 64'd0);
    checkOutput("reset.wreg", {63'd0, bus.wreg_o}, 64'd0);
    checkOutput("reset.whilo", {63'd0, bus.whilo_o}, 64'd0);
    checkOutput("reset.stall", {63'd0, bus.stallreq_o}, 64'd0);
    applyStimulus(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    rst = 1'b0;

    applyStimulus(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_F0F0, 32'h00FF_00FF, 5'd3, 1'b1);
    checkOutput("or.wdata", {32'd0, bus.wdata_o}, 64'h0000_0000_00FF_F0FF);
    checkComb("or");
    applyStimulus(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0010, 5'd4, 1'b1);
    checkOutput("sra.wdata", {32'd0, bus.wdata_o}, 64'h0000_0000_F800_0001);
    applyStimulus(EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0010, 5'd4, 1'b1);
    checkOutput("srl.wdata", {32'd0, bus.wdata_o}, 64'h0000_0000_0800_0001);
    applyStimulus(EXE_SRA_OP, EXE_RES_SHIFT, 32'd0, 32'h8000_0010, 5'd4, 1'b1);
    checkOutput("sra0.wdata", {32'd0, bus.wdata_o}, 64'h0000_0000_8000_0010);

    setHilo(32'h11, 32'h0, 1'b1, 32'h33, 32'h0, 1'b1, 32'h22, 32'h0);
    applyStimulus(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd5, 1'b1);
    checkOutput("mfhi.mem", {32'd0, bus.wdata_o}, 64'h33);
    bus.mem_whilo_i = 1'b0;
    #1;
    checkOutput("mfhi.wb", {32'd0, bus.wdata_o}, 64'h22);
    bus.wb_whilo_i = 1'b0;
    #1;
    checkOutput("mfhi.arch", {32'd0, bus.wdata_o}, 64'h11);

    applyStimulus(8'hFF, EXE_RES_LOGIC, 32'hFFFF_FFFF, 32'h1234_5678, 5'd6, 1'b1);
    checkOutput("unknown.wdata", {32'd0, bus.wdata_o}, 64'd0);
    checkOutput("unknown.whilo", {63'd0, bus.whilo_o}, 64'd0);

    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 12);
      setHilo($urandom, $urandom, 1'($urandom), $urandom, $urandom,
              1'($urandom), $urandom, $urandom);
      applyStimulus(ops[k].op, ops[k].sel, $urandom, $urandom,
                    5'($urandom), 1'($urandom));
      checkComb($sformatf("rand%0d", i));
    end

    runMult(1'b1, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
    runMult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    runMult(1'b1, 32'h1234_5678, 32'd0, "mult_zero");
    runMult(1'b1, 32'h8000_0000, 32'h8000_0000, "mult_minint");
    runMult(1'b1, 32'hFFFF_FFFF, 32'd1, "mult_neg1x1");

    // Abort a multiply with reset partway through BUSY.
    applyStimulus(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFF_FFFD, 32'd7, 5'd9, 1'b1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort.stall_in_rst", {63'd0, bus.stallreq_o}, 64'd0);
    checkOutput("abort.whilo_in_rst", {63'd0, bus.whilo_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.aluop_i = EXE_NOP_OP;
    #1;
    checkOutput("abort.stall_after", {63'd0, bus.stallreq_o}, 64'd0);
    checkOutput("abort.whilo_after", {63'd0, bus.whilo_o}, 64'd0);
    runMult(1'b1, 32'hFFFF_FFFD, 32'd7, "mult_after_abort");

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = (i == 2) ? 32'd0 : $urandom;
      b = $urandom;
      runMult(1'($urandom), a, b, $sformatf("mult_rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
